// File: rtl/gdiv_nch.sv
// gdiv_nch: multi-channel stochastic-bitstream divider; each channel uses a saturating
// up/down counter as a feedback integrator. Optional warm-up gating: GDIV_NCH_WARMUP_EN.

module gdiv_nch_lane #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          mode,
    input  logic          in_valid,
    input  logic [BW-1:0] rand_num,
    input  logic          dividend,
    input  logic          divisor,
    output logic          quotient,
    output logic          sat,
    output logic [BW-1:0] cnt
);
    localparam logic [BW-1:0] MID = {1'b1, {(BW-1){1'b0}}};

    logic q_c;
    logic prod;
    logic inc;
    logic dec;
    logic at_max;
    logic at_min;

    // Comparator turns the counter into the quotient bitstream, which is
    // multiplied back against the divisor and compared with the dividend.
    assign q_c    = (cnt > rand_num);
    assign prod   = mode ? ~(divisor ^ q_c) : (divisor & q_c);
    assign inc    = dividend & ~prod;
    assign dec    = ~dividend & prod;
    assign at_max = &cnt;
    assign at_min = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= MID;
            quotient <= 1'b0;
            sat      <= 1'b0;
        end else if (clr) begin
            cnt      <= MID;
            quotient <= 1'b0;
            sat      <= 1'b0;
        end else if (in_valid) begin
            quotient <= q_c;
            if (inc && !at_max)
                cnt <= cnt + BW'(1);
            else if (dec && !at_min)
                cnt <= cnt - BW'(1);
            // A blocked step is remembered until the channel is cleared.
            if ((inc && at_max) || (dec && at_min))
                sat <= 1'b1;
        end
    end
endmodule

module gdiv_nch #(
    parameter int BW     = 8,
    parameter int NCH    = 4,
    parameter int WARMUP = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic [NCH-1:0] mode,
    input  logic           in_valid,
    input  logic [BW-1:0]  rand_num,
    input  logic [NCH-1:0] dividend,
    input  logic [NCH-1:0] divisor,
    output logic [NCH-1:0] quotient,
    output logic           out_valid,
    output logic [NCH-1:0] sat
);
    logic [NCH-1:0][BW-1:0] cnt;
    logic                   warm_done;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        gdiv_nch_lane #(.BW(BW)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .mode     (mode[i]),
            .in_valid (in_valid),
            .rand_num (rand_num),
            .dividend (dividend[i]),
            .divisor  (divisor[i]),
            .quotient (quotient[i]),
            .sat      (sat[i]),
            .cnt      (cnt[i])
        );
    end

`ifdef GDIV_NCH_WARMUP_EN
    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WW-1:0] WARM_END = WW'(WARMUP);

    logic [WW-1:0] warm_cnt;

    // Counts accepted samples only; stops once the warm-up window is done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            warm_cnt <= '0;
        else if (clr)
            warm_cnt <= '0;
        else if (in_valid && !warm_done)
            warm_cnt <= warm_cnt + WW'(1);
    end

    assign warm_done = (warm_cnt == WARM_END);
`else
    logic unused_warmup;
    assign unused_warmup = (WARMUP != 0);
    assign warm_done     = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_valid <= 1'b0;
        else if (clr)
            out_valid <= 1'b0;
        else
            out_valid <= in_valid & warm_done;
    end
endmodule

// File: tb/tb_gdiv_nch.sv
// Randomized bench for gdiv_nch with an arithmetic reference model and literal anchor checks.

module tb_gdiv_nch;
    localparam int BW     = 4;
    localparam int NCH    = 2;
    localparam int WARMUP = 4;
    localparam int MAXV   = (1 << BW) - 1;
    localparam int MID    = 1 << (BW - 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0;
    logic [NCH-1:0] mode = '0;
    logic           in_valid = 1'b0;
    logic [BW-1:0]  rand_num = '0;
    logic [NCH-1:0] dividend = '0;
    logic [NCH-1:0] divisor = '0;
    logic [NCH-1:0] quotient;
    logic           out_valid;
    logic [NCH-1:0] sat;

    gdiv_nch #(.BW(BW), .NCH(NCH), .WARMUP(WARMUP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .mode      (mode),
        .in_valid  (in_valid),
        .rand_num  (rand_num),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .out_valid (out_valid),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_en = 1'b0;

    int  m_cnt [NCH];
    bit  m_q   [NCH];
    bit  m_sat [NCH];
    bit  m_ov;
    int  m_warm;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Product bit the divider feeds back, from the coding rules.
    function automatic bit prod_of(input bit md, input bit dv, input bit qc);
        return md ? (dv == qc) : (dv && qc);
    endfunction

    function automatic int next_cnt(input int c, input bit md, input bit dd, input bit dv, input int r);
        bit p;
        p = prod_of(md, dv, c > r);
        if (dd && !p) return (c < MAXV) ? c + 1 : c;
        if (!dd && p) return (c > 0) ? c - 1 : c;
        return c;
    endfunction

    function automatic bit blocked(input int c, input bit md, input bit dd, input bit dv, input int r);
        bit p;
        p = prod_of(md, dv, c > r);
        return (dd && !p && c == MAXV) || (!dd && p && c == 0);
    endfunction

    function automatic bit warm_ok(input int w);
`ifdef GDIV_NCH_WARMUP_EN
        return w == WARMUP;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] <= MID;
                m_q[i]   <= 1'b0;
                m_sat[i] <= 1'b0;
            end
            m_ov   <= 1'b0;
            m_warm <= 0;
        end else begin
            m_ov <= in_valid && warm_ok(m_warm);
            if (in_valid) begin
                if (m_warm < WARMUP) m_warm <= m_warm + 1;
                for (int i = 0; i < NCH; i++) begin
                    m_q[i]   <= m_cnt[i] > int'(rand_num);
                    m_cnt[i] <= next_cnt(m_cnt[i], mode[i], dividend[i], divisor[i], int'(rand_num));
                    if (blocked(m_cnt[i], mode[i], dividend[i], divisor[i], int'(rand_num)))
                        m_sat[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", int'(out_valid), int'(m_ov));
            for (int i = 0; i < NCH; i++) begin
                chk($sformatf("cnt%0d", i), int'(dut.cnt[i]), m_cnt[i]);
                chk($sformatf("quotient%0d", i), int'(quotient[i]), int'(m_q[i]));
                chk($sformatf("sat%0d", i), int'(sat[i]), int'(m_sat[i]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_cnt0", int'(dut.cnt[0]), 8);
        chk("rst_cnt1", int'(dut.cnt[1]), 8);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sat", int'(sat), 0);
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Warm-up gating, with the inputs chosen so counters hold.
        in_valid = 1'b1;
`ifdef GDIV_NCH_WARMUP_EN
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("warm_ov_%0d", k), int'(out_valid), (k < 5) ? 0 : 1);
        end
        in_valid = 1'b0;
        tick();
        chk("gap_ov_1", int'(out_valid), 0);
        tick();
        chk("gap_ov_2", int'(out_valid), 0);
        chk("gap_cnt0", int'(dut.cnt[0]), 8);
        in_valid = 1'b1;
        tick();
        chk("post_gap_ov", int'(out_valid), 1);
`else
        tick();
        chk("first_ov", int'(out_valid), 1);
        in_valid = 1'b0;
        tick();
        chk("gap_ov", int'(out_valid), 0);
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // ch0 climbs to the top and saturates; ch1 drains to zero.
        mode = 2'b00; rand_num = '0; dividend = 2'b01; divisor = 2'b10; in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 7) begin
                chk("up_cnt0_7", int'(dut.cnt[0]), 15);
                chk("up_sat0_7", int'(sat[0]), 0);
                chk("dn_cnt1_7", int'(dut.cnt[1]), 1);
            end
            if (k == 8) begin
                chk("up_cnt0_8", int'(dut.cnt[0]), 15);
                chk("up_sat0_8", int'(sat[0]), 1);
                chk("dn_cnt1_8", int'(dut.cnt[1]), 0);
                chk("dn_q1_8", int'(quotient[1]), 1);
            end
            if (k == 9) begin
                chk("dn_cnt1_9", int'(dut.cnt[1]), 0);
                chk("dn_sat1_9", int'(sat[1]), 0);
                chk("dn_q1_9", int'(quotient[1]), 0);
                chk("up_q0_9", int'(quotient[0]), 1);
            end
        end

        // Clear wins over a valid sample.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt0", int'(dut.cnt[0]), 8);
        chk("clr_cnt1", int'(dut.cnt[1]), 8);
        chk("clr_sat", int'(sat), 0);
        chk("clr_ov", int'(out_valid), 0);
        chk("clr_q", int'(quotient), 0);

        // Bipolar channel 0.
        mode = 2'b01; rand_num = 4'd15; dividend = 2'b01; divisor = 2'b01;
        tick();
        chk("bip_inc_cnt0", int'(dut.cnt[0]), 9);
        chk("bip_hold_cnt1", int'(dut.cnt[1]), 8);
        dividend = 2'b00; divisor = 2'b00;
        tick();
        chk("bip_dec_cnt0", int'(dut.cnt[0]), 8);

        // Randomized traffic with drifting bit densities, clears and async resets.
        for (int k = 0; k < 900; k++) begin
            int pd;
            int pv;
            pd = (k / 100) % 4;
            pv = ((k / 100) + 1) % 4;
            in_valid = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 63) == 0);
            mode     = NCH'($urandom);
            rand_num = BW'($urandom);
            for (int i = 0; i < NCH; i++) begin
                dividend[i] = ($urandom_range(0, 3) < pd);
                divisor[i]  = ($urandom_range(0, 3) < pv);
            end
            tick();
            if (k % 300 == 150) begin
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_ov", int'(out_valid), 0);
                chk("midrst_cnt0", int'(dut.cnt[0]), 8);
                chk("midrst_sat", int'(sat), 0);
                tick();
                rst_n = 1'b1;
            end
        end

        in_valid = 1'b0;
        clr      = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
